// File: rtl/arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package arb_pkg;
   localparam int DEF_DATA_WIDTH    = 48;
   localparam int DEF_ADDRESS_WIDTH = 8;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} arbStateT;
   typedef enum logic {OWNER_CPU, OWNER_LD} ownerT;
endpackage

// File: rtl/arb_priority_picker.sv
// Combinational winner selection between the CPU and loader requests.
module arb_priority_picker
   import arb_pkg::*;
(
   input  logic  cpuReq,
   input  logic  ldReq,
   input  ownerT ptr,
   output logic  grant,
   output ownerT winner
);
   always_comb begin
      grant  = cpuReq | ldReq;
      winner = OWNER_CPU;
      // The pointer only matters on a tie; a lone request always wins.
      if (cpuReq && ldReq) winner = ptr;
      else if (ldReq)      winner = OWNER_LD;
   end
endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates a CPU and an external loader onto one synchronous single-port memory.
// Define ARB_ROUND_ROBIN_EN for alternating tie priority; otherwise the CPU wins ties.
module memory_arbiter
   import arb_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
)(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0]    cpu_wdata,
   output logic [DATA_WIDTH-1:0]    cpu_rdata,
   output logic                     cpu_ack,
   output logic                     cpu_stall,
   input  logic                     ld_req,
   input  logic                     ld_we,
   input  logic [ADDRESS_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0]    ld_wdata,
   output logic [DATA_WIDTH-1:0]    ld_rdata,
   output logic                     ld_ack,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic                     busy
);
   arbStateT                 state;
   ownerT                    owner;
   ownerT                    ptr;
   ownerT                    winner;
   logic                     grant;
   logic                     latWe;
   logic                     memWe;
   logic                     cpuAckR;
   logic                     ldAckR;
   logic [ADDRESS_WIDTH-1:0] latAddr;
   logic [DATA_WIDTH-1:0]    latWdata;
   logic [DATA_WIDTH-1:0]    cpuHold;
   logic [DATA_WIDTH-1:0]    ldHold;

   arb_priority_picker uPicker (
      .cpuReq (cpu_req),
      .ldReq  (ld_req),
      .ptr    (ptr),
      .grant  (grant),
      .winner (winner)
   );

`ifndef ARB_ROUND_ROBIN_EN
   assign ptr = OWNER_CPU;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         owner    <= OWNER_CPU;
         latWe    <= 1'b0;
         latAddr  <= '0;
         latWdata <= '0;
         memWe    <= 1'b0;
         cpuAckR  <= 1'b0;
         ldAckR   <= 1'b0;
         cpuHold  <= '0;
         ldHold   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         ptr      <= OWNER_CPU;
`endif
      end else begin
         case (state)
            IDLE: if (grant) begin
               owner    <= winner;
               latWe    <= (winner == OWNER_LD) ? ld_we    : cpu_we;
               latAddr  <= (winner == OWNER_LD) ? ld_addr  : cpu_addr;
               latWdata <= (winner == OWNER_LD) ? ld_wdata : cpu_wdata;
               // Write strobe is registered so it is high for exactly the ISSUE cycle.
               memWe    <= (winner == OWNER_LD) ? ld_we    : cpu_we;
`ifdef ARB_ROUND_ROBIN_EN
               ptr      <= (winner == OWNER_CPU) ? OWNER_LD : OWNER_CPU;
`endif
               state    <= ISSUE;
            end
            ISSUE: begin
               memWe   <= 1'b0;
               cpuAckR <= (owner == OWNER_CPU);
               ldAckR  <= (owner == OWNER_LD);
               state   <= RESP;
            end
            RESP: begin
               cpuAckR <= 1'b0;
               ldAckR  <= 1'b0;
               if (cpuAckR) cpuHold <= mem_rdata;
               if (ldAckR)  ldHold  <= mem_rdata;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read data appears in RESP straight from memory, then is held until the next ack.
   assign cpu_rdata = cpuAckR ? mem_rdata : cpuHold;
   assign ld_rdata  = ldAckR  ? mem_rdata : ldHold;
   assign cpu_ack   = cpuAckR;
   assign ld_ack    = ldAckR;
   assign cpu_stall = cpu_req & ~cpuAckR;
   assign mem_we    = memWe;
   assign mem_addr  = latAddr;
   assign mem_wdata = latWdata;
   assign busy      = (state != IDLE);
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a transaction-level reference model.
module tb_memory_arbiter;
   localparam int DW = 48;
   localparam int AW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          cpu_req = 0, cpu_we = 0, ld_req = 0, ld_we = 0;
   logic [AW-1:0] cpu_addr = '0, ld_addr = '0;
   logic [DW-1:0] cpu_wdata = '0, ld_wdata = '0;
   logic [DW-1:0] cpu_rdata, ld_rdata, mem_wdata, memRdata;
   logic          cpu_ack, cpu_stall, ld_ack, mem_we, busy;
   logic [AW-1:0] mem_addr;

   logic          preWe = 0;
   logic [AW-1:0] preAddr = '0;
   logic [DW-1:0] preData = '0;
   logic [DW-1:0] tbMem [0:255];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   memory_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_rdata(ld_rdata), .ld_ack(ld_ack),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(memRdata),
      .busy(busy)
   );

   // Synchronous single-port memory, read-before-write.
   always @(posedge clock) begin
      if (preWe)       tbMem[preAddr]  <= preData;
      else if (mem_we) tbMem[mem_addr] <= mem_wdata;
      memRdata <= tbMem[mem_addr];
   end

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: each access is a three-phase transaction (0 idle, 1 issue, 2 respond).
   logic [DW-1:0] refMem [0:255];
   int            ph;
   bit            mOwnLd, mWe, mPtrLd, pickLd;
   logic [AW-1:0] mAddr;
   logic [DW-1:0] mWdata, mRead, mHoldCpu, mHoldLd;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         if (preWe) refMem[preAddr] = preData;
         ph = 0; mOwnLd = 0; mWe = 0; mPtrLd = 0;
         mAddr = '0; mWdata = '0; mRead = '0; mHoldCpu = '0; mHoldLd = '0;
      end else begin
         case (ph)
            0: if (cpu_req || ld_req) begin
`ifdef ARB_ROUND_ROBIN_EN
               pickLd = ld_req && (!cpu_req || mPtrLd);
               mPtrLd = !pickLd;
`else
               pickLd = !cpu_req;
`endif
               mOwnLd = pickLd;
               mWe    = pickLd ? ld_we    : cpu_we;
               mAddr  = pickLd ? ld_addr  : cpu_addr;
               mWdata = pickLd ? ld_wdata : cpu_wdata;
               ph = 1;
            end
            1: begin
               mRead = refMem[mAddr];
               if (mWe) refMem[mAddr] = mWdata;
               ph = 2;
            end
            default: begin
               if (mOwnLd) mHoldLd = mRead; else mHoldCpu = mRead;
               ph = 0;
            end
         endcase
      end
   end

   always @(negedge clock) begin
      logic expCpuAck, expLdAck;
      expCpuAck = (ph == 2) && !mOwnLd;
      expLdAck  = (ph == 2) && mOwnLd;
      chk("busy",      {47'd0, busy},      {47'd0, ph != 0});
      chk("cpu_ack",   {47'd0, cpu_ack},   {47'd0, expCpuAck});
      chk("ld_ack",    {47'd0, ld_ack},    {47'd0, expLdAck});
      chk("cpu_stall", {47'd0, cpu_stall}, {47'd0, cpu_req && !expCpuAck});
      chk("mem_we",    {47'd0, mem_we},    {47'd0, (ph == 1) && mWe});
      chk("mem_addr",  {40'd0, mem_addr},  {40'd0, mAddr});
      chk("mem_wdata", mem_wdata, mWdata);
      chk("cpu_rdata", cpu_rdata, expCpuAck ? mRead : mHoldCpu);
      chk("ld_rdata",  ld_rdata,  expLdAck  ? mRead : mHoldLd);
   end

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic waitAck(input bit ld, output int n);
      n = 0;
      while (!(ld ? ld_ack : cpu_ack) && n < 10) begin tick(); n++; end
      if (n >= 10) chk(ld ? "ld_ack timeout" : "cpu_ack timeout", 48'd0, 48'd1);
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      preWe = 1; preAddr = a; preData = d;
      tick();
      preWe = 0;
   endtask

   initial begin
      int n, n2;
      bit grants [4];
      bit expGrant [4];

      preload(8'h10, 48'hAABBCCDDEEFF);
      preload(8'h20, 48'h00000BADF00D);
      preload(8'hFF, 48'h111111111111);
      preload(8'h00, 48'h000000000000);
      chk("reset busy",     {47'd0, busy},   48'd0);
      chk("reset mem_we",   {47'd0, mem_we}, 48'd0);
      chk("reset mem_addr", {40'd0, mem_addr}, 48'd0);
      chk("reset cpu_rdata", cpu_rdata, 48'd0);
      reset = 1;
      tick();

      // CPU read alone
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
      waitAck(0, n);
      chk("cpu read latency", n, 2);
      chk("cpu read data", cpu_rdata, 48'hAABBCCDDEEFF);
      chk("cpu stall at ack", {47'd0, cpu_stall}, 48'd0);
      cpu_req = 0;
      tick();
      chk("cpu rdata held", cpu_rdata, 48'hAABBCCDDEEFF);

      // Loader write to the top address
      ld_req = 1; ld_we = 1; ld_addr = 8'hFF; ld_wdata = 48'h123456789ABC;
      tick();
      chk("ld write mem_we", {47'd0, mem_we}, 48'd1);
      chk("ld write mem_addr", {40'd0, mem_addr}, 48'h0000000000FF);
      chk("ld write mem_wdata", mem_wdata, 48'h123456789ABC);
      tick();
      chk("ld write ack", {47'd0, ld_ack}, 48'd1);
      chk("ld write mem_we off", {47'd0, mem_we}, 48'd0);
      ld_req = 0; ld_we = 0;
      tick();
      cpu_req = 1; cpu_addr = 8'hFF;
      waitAck(0, n);
      chk("cpu readback 0xFF", cpu_rdata, 48'h123456789ABC);
      cpu_req = 0;
      tick();

      // Back-to-back CPU accesses with req held across ack
      cpu_req = 1; cpu_addr = 8'h10;
      waitAck(0, n);
      tick();
      waitAck(0, n2);
      chk("back-to-back spacing", n2 + 1, 3);
      cpu_req = 0;
      tick();

      // Loader request arriving while the CPU access is in ISSUE
      cpu_req = 1; cpu_addr = 8'h10;
      tick();
      ld_req = 1; ld_we = 0; ld_addr = 8'h10;
      tick();
      chk("cpu ack before ld", {47'd0, cpu_ack}, 48'd1);
      chk("ld ignored", {47'd0, ld_ack}, 48'd0);
      cpu_req = 0;
      tick();
      chk("idle after cpu", {47'd0, busy}, 48'd0);
      waitAck(1, n);
      chk("ld late latency", n, 2);
      chk("ld late data", ld_rdata, 48'hAABBCCDDEEFF);
      ld_req = 0;
      tick();

      // Reset during ISSUE of a CPU write
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 48'hFFFFFFFFFFFF;
      tick();
      chk("abort write issued", {47'd0, mem_we}, 48'd1);
      #2 reset = 0;
      #1;
      chk("abort busy", {47'd0, busy}, 48'd0);
      chk("abort mem_we", {47'd0, mem_we}, 48'd0);
      chk("abort cpu_ack", {47'd0, cpu_ack}, 48'd0);
      cpu_req = 0; cpu_we = 0;
      tick();
      tick();
      chk("aborted write absent", tbMem[8'h20], 48'h00000BADF00D);
      reset = 1;
      tick();

      // Both requesters held for four accesses
      cpu_req = 1; cpu_addr = 8'h10;
      ld_req = 1; ld_addr = 8'hFF;
`ifdef ARB_ROUND_ROBIN_EN
      expGrant = '{0, 1, 0, 1};
`else
      expGrant = '{0, 0, 0, 0};
`endif
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!(cpu_ack || ld_ack) && n < 10) begin tick(); n++; end
         if (n >= 10) chk("tie grant timeout", 48'd0, 48'd1);
         grants[i] = ld_ack;
         chk($sformatf("tie grant %0d owner", i), {47'd0, grants[i]}, {47'd0, expGrant[i]});
         if (i < 3) tick();
      end
      cpu_req = 0; ld_req = 0;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 48, which is the memory word width (6 lanes x 8 bits).
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 8, which is the memory word address width.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports cpu_req / cpu_we, input, 1 bit each: CPU memory-stage access request and write flag.
REQ-006 The block SHALL have ports cpu_addr (input, ADDRESS_WIDTH) and cpu_wdata (input, DATA_WIDTH).
REQ-007 The block SHALL have ports cpu_rdata (output, DATA_WIDTH), cpu_ack (output, 1) and cpu_stall (output, 1).
REQ-008 The block SHALL have ports ld_req / ld_we (input, 1 each), ld_addr (input, ADDRESS_WIDTH) and ld_wdata (input, DATA_WIDTH): the external loader port.
REQ-009 The block SHALL have ports ld_rdata (output, DATA_WIDTH) and ld_ack (output, 1).
REQ-010 The block SHALL have ports mem_we (output, 1), mem_addr (output, ADDRESS_WIDTH) and mem_wdata (output, DATA_WIDTH): the shared single-port memory command.
REQ-011 The block SHALL have port mem_rdata, input, DATA_WIDTH: synchronous read data, valid 1 cycle after the address.
REQ-012 The block SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE and RESP; one access is completed per 3-cycle pass.
REQ-014 In IDLE with at least one request high, the block SHALL latch the winner's owner, we, addr and wdata, and go to ISSUE.
REQ-015 In ISSUE, the block SHALL drive mem_addr and mem_wdata from the latch, drive mem_we = latched we, and go to RESP.
REQ-016 In RESP, the block SHALL pulse the winner's ack for exactly 1 cycle and route mem_rdata to the winner's rdata, for both read and write accesses.
REQ-017 In RESP, mem_we SHALL be 0, and the next state SHALL be IDLE.
REQ-018 Latency SHALL be 2 cycles from the IDLE sampling edge to ack.
REQ-019 Requests SHALL be ignored outside IDLE.
REQ-020 A requester SHALL hold req and its operands stable until ack; a request still high after ack is treated as a new access.
REQ-021 Simultaneous requests SHALL be resolved by the priority pointer (see Configuration).
REQ-022 A lone request SHALL always win, regardless of the pointer.
REQ-023 cpu_stall SHALL equal cpu_req AND NOT cpu_ack (combinational).
REQ-024 rdata outputs SHALL hold their last value when not acked.
REQ-025 mem_we SHALL be high only in ISSUE.
REQ-026 An address at the maximum value (all ones) SHALL be passed through unchanged, with no wrap or increment.

Reset
REQ-027 On reset low, the block SHALL go immediately to IDLE, with mem_we=0, cpu_ack=0, ld_ack=0, busy=0, all data/address outputs 0, and the pointer favouring the CPU.
REQ-028 A reset asserted in ISSUE or RESP SHALL abort the access without ack; a write aborted before ISSUE's clock edge SHALL not reach memory.
REQ-029 After reset deasserts, the first sampling edge SHALL be in IDLE.

Configuration
REQ-030 With ARB_ROUND_ROBIN_EN defined, the pointer SHALL toggle to the non-winner after every grant.
REQ-031 With ARB_ROUND_ROBIN_EN not defined, the CPU SHALL always win ties (fixed priority) and the pointer logic SHALL be absent.

Structure
REQ-032 Package arb_pkg SHALL hold the state enum (IDLE, ISSUE, RESP), the owner enum (OWNER_CPU, OWNER_LD) and the default width constants.
REQ-033 A sub-module arb_priority_picker SHALL perform the combinational winner selection from the two reqs and the pointer.
REQ-034 The FSM and latches SHALL be in memory_arbiter.

Verification
REQ-035 The bench SHALL cover a CPU read alone: cpu_req=1, we=0, addr=0x10, mem[0x10]=0xAABBCCDDEEFF -> cpu_ack 2 cycles later with cpu_rdata=0xAABBCCDDEEFF, and cpu_stall=1 for exactly 2 cycles.
REQ-036 The bench SHALL cover a loader write: ld_we=1, addr=0xFF, wdata=0x123456789ABC -> mem_we=1 for 1 cycle at addr 0xFF, then ld_ack 1 cycle; a CPU read of 0xFF then returns 0x123456789ABC.
REQ-037 The bench SHALL cover both requests held high for 4 accesses with ARB_ROUND_ROBIN_EN -> grant order CPU, LD, CPU, LD; without the macro -> CPU, CPU, CPU, CPU while cpu_req is held.
REQ-038 The bench SHALL cover reset asserted during ISSUE of a CPU write to 0x20 -> no ack, busy=0 immediately, and mem[0x20] is not written if reset precedes the ISSUE edge.
REQ-039 The bench SHALL cover back-to-back CPU requests: req held across ack -> the second access acks 3 cycles after the first.
REQ-040 The bench SHALL cover a loader request arriving during a CPU ISSUE -> it is ignored until IDLE, then granted, with ld_ack 2 cycles after that IDLE edge.
